isdu_param: RTL

- Parametrised LC-3 instruction sequencer/decoder (ISDU). It drives every datapath load, gate and mux select, plus the memory strobes.
- Memory-access states use a single wait counter, or an optional ready handshake, instead of unrolled per-cycle states, so SRAM latency is a parameter.
- Adds full decode of LD, ST, LDI, STI, LEA and JSRR, plus a one-cycle Instr_Done strobe for the bench and debug.
- Sits between the IR/BEN logic and the datapath in the slc3 top level.

---
 rtl/isdu_pkg.sv | 46 ++++
 rtl/isdu_mem_timer.sv | 31 +++
 rtl/isdu_param.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/isdu_pkg.sv
// Shared types and encodings for the LC-3 sequencer: state enum, datapath mux codes, opcodes.
package isdu_pkg;

  typedef enum logic [4:0] {
    HALTED, F18, F33, F35, D32,
    S_ADD, S_AND, S_NOT,
    S0, S2, S3, S4, S6, S7, S10, S11, S12, S14,
    S20, S21, S22, S23, S26, S27, S31,
    R24, R25, R29, W16,
    PAUSE1, PAUSE2
  } state_t;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  function automatic logic is_mem_state(state_t s);
    return (s == F33) || (s == R24) || (s == R25) || (s == R29) || (s == W16);
  endfunction

endpackage

// File: rtl/isdu_mem_timer.sv
// Shared wait counter for all memory states; flags the final cycle of an access.
module isdu_mem_timer
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT      = 4,
  parameter bit MEM_HANDSHAKE = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic active,
  input  logic Mem_Ready,
  output logic mem_last
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Memory states are never back-to-back, so idling at zero doubles as "clear on entry".
  always_comb begin
    mem_last = active && (MEM_HANDSHAKE ? Mem_Ready : (cnt_q == CNT_LAST));
    cnt_d    = (active && !mem_last) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/isdu_param.sv
// LC-3 instruction sequencer/decoder with parametrised memory latency or ready handshake.
module isdu_param
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT      = 4,
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter bit PAUSE_EN      = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE, Mem_WE,
  output logic       Instr_Done
);

  state_t state_q, state_d;
  logic   mem_last;

  isdu_mem_timer #(.MEM_WAIT(MEM_WAIT), .MEM_HANDSHAKE(MEM_HANDSHAKE)) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .active   (is_mem_state(state_q)),
    .Mem_Ready(Mem_Ready),
    .mem_last (mem_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= HALTED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX} = '0;
    PCMUX = PCMUX_PC1; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b0; Mem_WE = 1'b0; Instr_Done = 1'b0;
    case (state_q)
      HALTED: if (Run) state_d = F18;
      F18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; state_d = F33; end
      F33: begin Mem_OE = 1'b1; LD_MDR = mem_last; if (mem_last) state_d = F35; end
      F35: begin GateMDR = 1'b1; LD_IR = 1'b1; state_d = D32; end
      D32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD: state_d = S_ADD;
          OP_AND: state_d = S_AND;
          OP_NOT: state_d = S_NOT;
          OP_LD:  state_d = S2;
          OP_ST:  state_d = S3;
          OP_LDR: state_d = S6;
          OP_STR: state_d = S7;
          OP_LDI: state_d = S10;
          OP_STI: state_d = S11;
          OP_LEA: state_d = S14;
          OP_BR:  state_d = S0;
          OP_JMP: state_d = S12;
          OP_JSR: state_d = S4;
          OP_PSE: begin
            state_d = PAUSE_EN ? PAUSE1 : F18;
            Instr_Done = !PAUSE_EN;
          end
          default: begin state_d = F18; Instr_Done = 1'b1; end
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1;
        Instr_Done = 1'b1; state_d = F18;
        SR2MUX = (state_q != S_NOT) && IR_5;
        ALUK = (state_q == S_ADD) ? ALUK_ADD : (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S2, S3, S10, S11: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR2MUX = ADDR2_OFF9;
        state_d = (state_q == S2) ? R25 : (state_q == S3) ? S23 : (state_q == S10) ? R24 : R29;
      end
      S6, S7: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; SR1MUX = 1'b1;
        ADDR2MUX = ADDR2_OFF6;
        state_d = (state_q == S6) ? R25 : S23;
      end
      R24, R25, R29: begin
        Mem_OE = 1'b1; LD_MDR = mem_last;
        if (mem_last) state_d = (state_q == R24) ? S26 : (state_q == R25) ? S27 : S31;
      end
      // Indirect pointer: the fetched word becomes the next address.
      S26, S31: begin
        GateMDR = 1'b1; LD_MAR = 1'b1;
        state_d = (state_q == S26) ? R25 : S23;
      end
      S23: begin GateALU = 1'b1; ALUK = ALUK_PASSA; LD_MDR = 1'b1; state_d = W16; end
      W16: begin Mem_WE = 1'b1; Instr_Done = mem_last; if (mem_last) state_d = F18; end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; Instr_Done = 1'b1; state_d = F18;
      end
      S14: begin
        GateMARMUX = 1'b1; ADDR2MUX = ADDR2_OFF9; LD_REG = 1'b1;
        Instr_Done = 1'b1; state_d = F18;
      end
      S0: begin
        state_d = BEN ? S22 : F18;
        Instr_Done = !BEN;
      end
      S22: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDR; ADDR2MUX = ADDR2_OFF9;
        Instr_Done = 1'b1; state_d = F18;
      end
      S12: begin
        GateALU = 1'b1; ALUK = ALUK_PASSA; SR1MUX = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_BUS;
        Instr_Done = 1'b1; state_d = F18;
      end
      S4: begin
        GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 1'b1;
        state_d = IR_11 ? S21 : S20;
      end
      S21: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDR; ADDR2MUX = ADDR2_OFF11;
        Instr_Done = 1'b1; state_d = F18;
      end
      S20: begin
        LD_PC = 1'b1; PCMUX = PCMUX_ADDR; ADDR1MUX = 1'b1; SR1MUX = 1'b1;
        Instr_Done = 1'b1; state_d = F18;
      end
      PAUSE1: begin LD_LED = 1'b1; if (Continue) state_d = PAUSE2; end
      PAUSE2: begin LD_LED = 1'b1; if (!Continue) state_d = F18; end
      default: state_d = HALTED;
    endcase
  end

endmodule
